muldiv_unit: RTL and testbench

//  Multi-cycle integer multiply/divide engine for the EX stage; successor to the single-op divider.

---
 rtl/muldiv_pkg.sv | 48 ++++
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_div_core.sv | 59 +++++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// MULDIV_ACC_EN enables the multiply-accumulate op codes.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  // Odd encodings are the unsigned variants.
  function automatic logic op_is_signed(muldiv_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_acc(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_is_legal(muldiv_op_t op);
`ifdef MULDIV_ACC_EN
    return (op == op);
`else
    return ~op[2];
`endif
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and muldiv_unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  import muldiv_pkg::*;

  logic               start_i;
  muldiv_op_t         op_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic [2*WIDTH-1:0] acc_i;
  logic               flush_i;
  logic               ready_i;
  logic               busy_o;
  logic               valid_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div_zero_o;

  modport master (
    output start_i, op_i, a_i, b_i, acc_i, flush_i, ready_i,
    input  busy_o, valid_o, result_o, div_zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, acc_i, flush_i, ready_i,
    output busy_o, valid_o, result_o, div_zero_o
  );

endinterface

// File: rtl/muldiv_div_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, done pulse after WIDTH steps.
module muldiv_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q, done_q;
  logic [WIDTH:0]   part_c, diff_c;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign part_c = {rem_q, quo_q[WIDTH-1]};
  assign diff_c = part_c - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        quo_q <= {quo_q[WIDTH-2:0], ~diff_c[WIDTH]};
        rem_q <= diff_c[WIDTH] ? part_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide engine with HI/LO-style 2*WIDTH result.
// Define MULDIV_ACC_EN to add MADD/MADDU/MSUB/MSUBU (acc_i +/- product).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 2);

  state_t           state_q;
  logic             busy_q, valid_q, dz_q, bzero_q, ill_q, a_neg_q, q_neg_q;
  logic [WIDTH-1:0] a_q;
  logic [DW-1:0]    result_q;
  logic [DW-1:0]    pipe_q [MUL_LAT];
  logic [CNT_W-1:0] cnt_q;
`ifdef MULDIV_ACC_EN
  muldiv_op_t       op_q;
  logic [DW-1:0]    acc_q;
`endif

  logic             sgn_c, a_neg_c, b_neg_c, accept_c, div_go_c, div_done;
  logic [DW-1:0]    prod_c, mul_res_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c, quo, rem, quo_fix_c, rem_fix_c;
  logic [CNT_W-1:0] lat_c;

  assign sgn_c    = op_is_signed(bus.op_i);
  assign a_neg_c  = sgn_c & bus.a_i[WIDTH-1];
  assign b_neg_c  = sgn_c & bus.b_i[WIDTH-1];
  assign prod_c   = {{WIDTH{a_neg_c}}, bus.a_i} * {{WIDTH{b_neg_c}}, bus.b_i};
  assign a_abs_c  = a_neg_c ? (-bus.a_i) : bus.a_i;
  assign b_abs_c  = b_neg_c ? (-bus.b_i) : bus.b_i;
  assign accept_c = bus.start_i & ~bus.flush_i &
                    ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.ready_i));
  assign div_go_c = accept_c & op_is_div(bus.op_i) & (bus.b_i != '0);

  // Magnitude quotient is negated when operand signs differ; remainder follows the dividend.
  assign quo_fix_c = q_neg_q ? (-quo) : quo;
  assign rem_fix_c = a_neg_q ? (-rem) : rem;

  muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_go_c),
    .dividend_i (a_abs_c),
    .divisor_i  (b_abs_c),
    .done_o     (div_done),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  // Cycles spent in S_MUL after the accept edge, minus one.
  always_comb begin
    lat_c = CNT_W'(MUL_LAT - 1);
`ifdef MULDIV_ACC_EN
    if (op_is_acc(bus.op_i)) lat_c = CNT_W'(MUL_LAT);
`endif
    if (!op_is_legal(bus.op_i)) lat_c = '0;
  end

  always_comb begin
    mul_res_c = pipe_q[MUL_LAT-1];
`ifdef MULDIV_ACC_EN
    if (op_is_acc(op_q)) begin
      mul_res_c = op_is_sub(op_q) ? (acc_q - pipe_q[MUL_LAT-1]) : (acc_q + pipe_q[MUL_LAT-1]);
    end
`endif
    if (ill_q) mul_res_c = '0;
  end

  // Product retiming chain; the last stage holds once the chain has filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MUL_LAT); i++) pipe_q[i] <= '0;
    end else begin
      if (accept_c) pipe_q[0] <= prod_c;
      if (state_q == S_MUL) begin
        for (int i = 1; i < int'(MUL_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dz_q     <= 1'b0;
      bzero_q  <= 1'b0;
      ill_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      a_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
`ifdef MULDIV_ACC_EN
      op_q     <= MD_MULT;
      acc_q    <= '0;
`endif
    end else if (bus.flush_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_MUL: begin
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= mul_res_c;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (bzero_q) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            dz_q     <= 1'b1;
            result_q <= {a_q, {WIDTH{1'b1}}};
          end else if (div_done) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= {rem_fix_c, quo_fix_c};
          end
        end
        S_DONE: begin
          if (bus.ready_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
          end
        end
        default: ;
      endcase
      // A new op overrides the DONE->IDLE return on a back-to-back handshake.
      if (accept_c) begin
        state_q <= op_is_div(bus.op_i) ? S_DIV : S_MUL;
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
        dz_q    <= 1'b0;
        bzero_q <= (bus.b_i == '0);
        ill_q   <= ~op_is_legal(bus.op_i);
        a_neg_q <= a_neg_c;
        q_neg_q <= a_neg_c ^ b_neg_c;
        a_q     <= bus.a_i;
        cnt_q   <= lat_c;
`ifdef MULDIV_ACC_EN
        op_q    <= bus.op_i;
        acc_q   <= bus.acc_i;
`endif
      end
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.valid_o    = valid_q;
  assign bus.result_o   = result_q;
  assign bus.div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops, handshake stalls, flush and reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned ML      = 3;
  localparam int          DIV_LAT = W + 1;

  typedef struct {
    string          name;
    logic [2*W-1:0] res;
    logic           dz;
    int             lat;
    int             c0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each presented result against the oldest expectation.
  initial begin : monitor
    exp_t           e;
    logic           seen, stable, d0;
    int             held, lat_meas;
    logic [2*W-1:0] r0;
    seen = 1'b0; stable = 1'b1; d0 = 1'b0; held = 0; lat_meas = 0; r0 = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        seen = 1'b0;
      end else if (bus.valid_o) begin
        if (!seen) begin
          seen = 1'b1; stable = 1'b1; held = 0;
          r0 = bus.result_o; d0 = bus.div_zero_o;
          lat_meas = (sb.size() > 0) ? (cyc - sb[0].c0) : 0;
        end else begin
          held++;
          if (bus.result_o !== r0 || bus.div_zero_o !== d0) stable = 1'b0;
        end
        if (bus.ready_i) begin
          seen = 1'b0;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got %h with no op outstanding, required none", bus.result_o);
          end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, r0, e.res);
            check({e.name, "_div_zero"}, 64'(d0), 64'(e.dz));
            check({e.name, "_latency"}, 64'(lat_meas), 64'(e.lat));
            if (held > 0) check({e.name, "_stable"}, 64'(stable), 64'd1);
          end
        end
      end
    end
  end

  // Called right after a negedge; returns 1 time unit after the accept edge.
  task automatic issue(input string name, input muldiv_op_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] acc, input logic do_exp,
                       input logic [2*W-1:0] res, input logic dz, input int lat);
    exp_t e;
    bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.acc_i = acc;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0; bus.op_i = MD_DIVU; bus.a_i = '1; bus.b_i = '1; bus.acc_i = '1;
    if (do_exp) begin
      e.name = name; e.res = res; e.dz = dz; e.lat = lat; e.c0 = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy_o || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
      sb.delete();
    end
  endtask

  task automatic run(input string name, input muldiv_op_t op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [2*W-1:0] acc,
                     input logic [2*W-1:0] res, input logic dz, input int lat);
    issue(name, op, a, b, acc, 1'b1, res, dz, lat);
    wait_idle(name, 80);
  endtask

  initial begin : stim
    int n;
    bus.start_i = 1'b0; bus.op_i = MD_MULT; bus.a_i = '0; bus.b_i = '0; bus.acc_i = '0;
    bus.flush_i = 1'b0; bus.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    check("rst_div_zero", 64'(bus.div_zero_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("mult_neg",   MD_MULT,  32'hFFFF_FFFE, 32'd3, '0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, ML);
    run("multu",      MD_MULTU, 32'hFFFF_FFFE, 32'd3, '0, 64'h0000_0002_FFFF_FFFA, 1'b0, ML);
    run("multu_max",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 64'hFFFF_FFFE_0000_0001, 1'b0, ML);
    run("div_neg",    MD_DIV,   32'hFFFF_FFF9, 32'd2, '0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_LAT);
    run("divu",       MD_DIVU,  32'd7, 32'd2, '0, {32'd1, 32'd3}, 1'b0, DIV_LAT);
    run("div_min",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '0, {32'd0, 32'h8000_0000}, 1'b0, DIV_LAT);
    run("div_negdvs", MD_DIV,   32'd100, 32'hFFFF_FFF9, '0, {32'd2, 32'hFFFF_FFF2}, 1'b0, DIV_LAT);
    run("div_negdvd", MD_DIV,   32'hFFFF_FF9C, 32'd7, '0, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, DIV_LAT);
    run("divu_zero",  MD_DIVU,  32'd5, 32'd0, '0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 1);
    run("div_zero",   MD_DIV,   32'hFFFF_FFF9, 32'd0, '0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1, 1);
`ifdef MULDIV_ACC_EN
    run("madd",       MD_MADD,  32'd3, 32'd4, 64'h10, 64'h1C, 1'b0, ML + 1);
    run("msub",       MD_MSUB,  32'd3, 32'd4, 64'h10, 64'h04, 1'b0, ML + 1);
`else
    run("illegal_madd",  MD_MADD,  32'd3, 32'd4, 64'h10, 64'h0, 1'b0, 1);
    run("illegal_msubu", MD_MSUBU, 32'd3, 32'd4, 64'h10, 64'h0, 1'b0, 1);
`endif

    // Result held while the consumer stalls, then a back-to-back op on the handshake edge.
    bus.ready_i = 1'b0;
    issue("hold_divu", MD_DIVU, 32'd7, 32'd2, '0, 1'b1, {32'd1, 32'd3}, 1'b0, DIV_LAT);
    n = 0;
    @(negedge clk);
    while (!bus.valid_o && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_seen", 64'(bus.valid_o), 64'd1);
    repeat (10) @(negedge clk);
    bus.ready_i = 1'b1;
    issue("b2b_mult", MD_MULT, 32'd4, 32'd5, '0, 1'b1, 64'd20, 1'b0, ML);
    check("b2b_busy", 64'(bus.busy_o), 64'd1);
    wait_idle("b2b_mult", 80);

    // A start while busy is dropped, not queued.
    issue("ign_divu", MD_DIVU, 32'd100, 32'd7, '0, 1'b1, {32'd2, 32'd14}, 1'b0, DIV_LAT);
    repeat (4) @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = MD_MULTU; bus.a_i = 32'd9; bus.b_i = 32'd9;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("ign_busy", 64'(bus.busy_o), 64'd1);
    wait_idle("ign_divu", 80);

    // Flush wins over a simultaneous start.
    bus.flush_i = 1'b1; bus.start_i = 1'b1; bus.op_i = MD_MULT; bus.a_i = 32'd2; bus.b_i = 32'd2;
    @(posedge clk);
    #1;
    check("flush_start_busy", 64'(bus.busy_o), 64'd0);
    bus.flush_i = 1'b0; bus.start_i = 1'b0;
    @(negedge clk);

    // Flush in the middle of a divide.
    issue("flush_div", MD_DIV, 32'hFFFF_FFF9, 32'd2, '0, 1'b0, '0, 1'b0, 0);
    repeat (9) @(negedge clk);
    check("flush_div_busy_before", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    check("flush_div_busy", 64'(bus.busy_o), 64'd0);
    check("flush_div_valid", 64'(bus.valid_o), 64'd0);
    bus.flush_i = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    issue("rst_mult", MD_MULT, 32'd6, 32'd7, '0, 1'b0, '0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus.busy_o), 64'd0);
    check("rst_mid_valid", 64'(bus.valid_o), 64'd0);
    check("rst_mid_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid_no_valid", 64'(bus.valid_o), 64'd0);

    run("mult_after_rst", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 64'd1, 1'b0, ML);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
